// File: rtl/param_hex_counter_pkg.sv
// Shared definitions for the hex counter: segment vector type, the
// active-low seven-segment glyph table and the blank pattern.
// Segment bit order: bit 0 = a ... bit 6 = g, 0 = segment lit.
package param_hex_counter_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned GLYPHS   = 16;

  typedef logic [SEG_W-1:0] seg_t;

  typedef logic [GLYPHS-1:0][SEG_W-1:0] glyph_table_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Index n holds the glyph for hex digit n (0-9, A, b, C, d, E, F).
  localparam glyph_table_t SEG_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage : param_hex_counter_pkg

// File: rtl/seg7_decoder.sv
// Combinational hex-nibble to active-low seven-segment decoder.
// Ports:
//   nibble : 4-bit value to display
//   seg    : active-low segments, bit 0 = a ... bit 6 = g
module seg7_decoder
  import param_hex_counter_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output seg_t                seg
);

  // Every 4-bit code has a glyph, so a plain table lookup suffices.
  assign seg = SEG_GLYPHS[nibble];

endmodule : seg7_decoder

// File: rtl/param_hex_counter.sv
// Parameterised up/down counter with parallel load, cascadable terminal
// count and per-nibble seven-segment display outputs.
// Parameters:
//   WIDTH     : count width, multiple of 4 in 4..32
//   MAX_COUNT : inclusive terminal count, 1..2**WIDTH-1
// Ports:
//   clock      : single clock, rising edge
//   clear_b    : asynchronous active-low clear, forces count to 0
//   enable     : count enable
//   up_down    : 1 = count up, 0 = count down
//   load       : synchronous parallel load (highest priority)
//   load_value : value loaded, clamped to MAX_COUNT
//   count      : registered counter value
//   tc         : combinational terminal-count flag for cascading
//   hex        : combinational active-low digits, digit i in hex[7i+6:7i]
// Build option:
//   PARAM_HEX_COUNTER_SATURATE_EN : hold at the terminal values instead of
//                                   wrapping
module param_hex_counter
  import param_hex_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
  input  logic                            clock,
  input  logic                            clear_b,
  input  logic                            enable,
  input  logic                            up_down,
  input  logic                            load,
  input  logic [WIDTH-1:0]                load_value,
  output logic [WIDTH-1:0]                count,
  output logic                            tc,
  output logic [SEG_W*(WIDTH/NIBBLE_W)-1:0] hex
);

  localparam int unsigned DIGITS = WIDTH / NIBBLE_W;

`ifdef PARAM_HEX_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_TERM_NEXT   = MAX_COUNT;
  localparam logic [WIDTH-1:0] DOWN_TERM_NEXT = '0;
`else
  localparam logic [WIDTH-1:0] UP_TERM_NEXT   = '0;
  localparam logic [WIDTH-1:0] DOWN_TERM_NEXT = MAX_COUNT;
`endif

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_zero;

  assign at_max       = (count == MAX_COUNT);
  assign at_zero      = (count == '0);
  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  // Next-state: load > enable > hold; direction applies on the same edge.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_clamped;
    end else if (enable) begin
      if (up_down) begin
        count_next = at_max ? UP_TERM_NEXT : count + WIDTH'(1);
      end else begin
        count_next = at_zero ? DOWN_TERM_NEXT : count - WIDTH'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Zero-latency terminal count so a following stage can chain on it.
  assign tc = enable & ~load & ((up_down & at_max) | (~up_down & at_zero));

  // One decoder per nibble; display follows count in the same cycle.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    seg7_decoder u_seg7_decoder (
      .nibble (count[gi*NIBBLE_W +: NIBBLE_W]),
      .seg    (hex[gi*SEG_W +: SEG_W])
    );
  end

endmodule : param_hex_counter

// File: tb/tb_param_hex_counter.sv
// Self-checking bench for param_hex_counter: five instances with different
// WIDTH/MAX_COUNT share one clock and clear; a reference model pushes the
// expected next count into a scoreboard that is drained after each edge.
module tb_param_hex_counter;

  localparam int N = 5;

  localparam logic [31:0] MAXV   [N] = '{32'd255, 32'd9, 32'd100, 32'd4095, 32'd15};
  localparam logic [31:0] MASK   [N] = '{32'hFF, 32'hFF, 32'hFF, 32'hFFF, 32'hF};
  localparam int          DIGITS [N] = '{2, 2, 2, 3, 1};

`ifdef PARAM_HEX_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int          inst;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear_b;
  logic        en [N];
  logic        ud [N];
  logic        ld [N];
  logic [31:0] lv [N];
  logic        tc_o [N];

  logic [7:0]  cnt_a, cnt_b, cnt_c;
  logic [11:0] cnt_d;
  logic [3:0]  cnt_e;
  logic [13:0] hex_a, hex_b, hex_c;
  logic [20:0] hex_d;
  logic [6:0]  hex_e;

  logic [31:0] cnt_obs [N];
  logic [31:0] hex_obs [N];
  logic [31:0] m_cnt   [N];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  assign cnt_obs[0] = 32'(cnt_a);
  assign cnt_obs[1] = 32'(cnt_b);
  assign cnt_obs[2] = 32'(cnt_c);
  assign cnt_obs[3] = 32'(cnt_d);
  assign cnt_obs[4] = 32'(cnt_e);
  assign hex_obs[0] = 32'(hex_a);
  assign hex_obs[1] = 32'(hex_b);
  assign hex_obs[2] = 32'(hex_c);
  assign hex_obs[3] = 32'(hex_d);
  assign hex_obs[4] = 32'(hex_e);

  param_hex_counter #(.WIDTH(8)) u_dut_a (
    .clock(clock), .clear_b(clear_b), .enable(en[0]), .up_down(ud[0]),
    .load(ld[0]), .load_value(lv[0][7:0]), .count(cnt_a), .tc(tc_o[0]), .hex(hex_a));

  param_hex_counter #(.WIDTH(8), .MAX_COUNT(8'd9)) u_dut_b (
    .clock(clock), .clear_b(clear_b), .enable(en[1]), .up_down(ud[1]),
    .load(ld[1]), .load_value(lv[1][7:0]), .count(cnt_b), .tc(tc_o[1]), .hex(hex_b));

  param_hex_counter #(.WIDTH(8), .MAX_COUNT(8'd100)) u_dut_c (
    .clock(clock), .clear_b(clear_b), .enable(en[2]), .up_down(ud[2]),
    .load(ld[2]), .load_value(lv[2][7:0]), .count(cnt_c), .tc(tc_o[2]), .hex(hex_c));

  param_hex_counter #(.WIDTH(12)) u_dut_d (
    .clock(clock), .clear_b(clear_b), .enable(en[3]), .up_down(ud[3]),
    .load(ld[3]), .load_value(lv[3][11:0]), .count(cnt_d), .tc(tc_o[3]), .hex(hex_d));

  param_hex_counter #(.WIDTH(4)) u_dut_e (
    .clock(clock), .clear_b(clear_b), .enable(en[4]), .up_down(ud[4]),
    .load(ld[4]), .load_value(lv[4][3:0]), .count(cnt_e), .tc(tc_o[4]), .hex(hex_e));

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] hex_model(logic [31:0] c, int d);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++) r[k*7 +: 7] = glyph(c[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] model_next(int i, logic [31:0] c);
    logic [31:0] v = lv[i] & MASK[i];
    if (ld[i]) return (v > MAXV[i]) ? MAXV[i] : v;
    if (!en[i]) return c;
    if (ud[i]) begin
      if (c == MAXV[i]) return SAT ? MAXV[i] : 32'd0;
      return c + 32'd1;
    end
    if (c == 32'd0) return SAT ? 32'd0 : MAXV[i];
    return c - 32'd1;
  endfunction

  function automatic logic exp_tc(int i);
    return en[i] & ~ld[i] & ((ud[i] & (m_cnt[i] == MAXV[i])) |
                             (~ud[i] & (m_cnt[i] == 32'd0)));
  endfunction

  // Check tc against current state, queue next count, clock, then drain.
  task automatic run_cycle(string tag);
    exp_t e;
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_tc%0d", tag, i), 32'(tc_o[i]), 32'(exp_tc(i)));
      sb.push_back('{i, model_next(i, m_cnt[i]), tag});
    end
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      m_cnt[e.inst] = e.cnt;
      check_eq($sformatf("%s_cnt%0d", e.tag, e.inst), cnt_obs[e.inst], e.cnt);
      check_eq($sformatf("%s_hex%0d", e.tag, e.inst), hex_obs[e.inst],
               hex_model(e.cnt, DIGITS[e.inst]));
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; ud[i] = 1'b1; ld[i] = 1'b0; lv[i] = '0;
    end
  endtask

  logic [31:0] exp_word;

  initial begin
    clear_b = 1'b0;
    idle_all();
    for (int i = 0; i < N; i++) m_cnt[i] = '0;

    // Reset state.
    #12;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("rst_cnt%0d", i), cnt_obs[i], 32'd0);
      check_eq($sformatf("rst_hex%0d", i), hex_obs[i], hex_model(32'd0, DIGITS[i]));
      check_eq($sformatf("rst_tc%0d", i), 32'(tc_o[i]), 32'd0);
    end
    clear_b = 1'b1;

    // Free run: A/C/D/E up, B down across its wrap.
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    ud[1] = 1'b0;
    for (int c = 0; c < 257; c++) run_cycle("run");

    // Direction flips every cycle.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) ud[i] = c[0];
      run_cycle("dir");
    end

    // Loads: clamp, load beats enable, 12-bit display.
    idle_all();
    ld[2] = 1'b1; lv[2] = 32'hC8; en[2] = 1'b1;
    ld[3] = 1'b1; lv[3] = 32'hA3F;
    ld[4] = 1'b1; lv[4] = 32'hF;
    run_cycle("load");
    check_eq("load_clamp100", cnt_obs[2], 32'd100);
    exp_word = 32'({7'b0001000, 7'b0110000, 7'b0001110});
    check_eq("hex_a3f", hex_obs[3], exp_word);

    // Terminal behaviour at the top, then at zero, for the 4-bit counter.
    idle_all();
    en[4] = 1'b1; ud[4] = 1'b1;
    for (int c = 0; c < 3; c++) run_cycle("top");
    ld[4] = 1'b1; lv[4] = 32'h0;
    run_cycle("ld0");
    ld[4] = 1'b0; ud[4] = 1'b0;
    for (int c = 0; c < 2; c++) run_cycle("bot");

    // Randomised mix.
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++) begin
        en[i] = 1'($urandom_range(0, 3) != 0);
        ud[i] = 1'($urandom_range(0, 1));
        ld[i] = 1'($urandom_range(0, 7) == 0);
        lv[i] = $urandom;
      end
      run_cycle("rnd");
    end

    // Asynchronous clear while A sits at 8'h5A and C is mid-load.
    idle_all();
    ld[0] = 1'b1; lv[0] = 32'h5A;
    run_cycle("ld5a");
    check_eq("cnt_5a", cnt_obs[0], 32'h5A);
    ld[0] = 1'b0; en[0] = 1'b1; ud[0] = 1'b0;
    ld[2] = 1'b1; lv[2] = 32'h33;
    #2;
    clear_b = 1'b0;
    #1;
    check_eq("clr_cnt_a", cnt_obs[0], 32'd0);
    exp_word = 32'({7'b1000000, 7'b1000000});
    check_eq("clr_hex_a", hex_obs[0], exp_word);
    check_eq("clr_tc_a", 32'(tc_o[0]), 32'd1);
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("clr_hold_cnt%0d", i), cnt_obs[i], 32'd0);
      m_cnt[i] = '0;
    end
    clear_b = 1'b1;
    ld[2] = 1'b0; en[2] = 1'b1; ud[2] = 1'b1;
    run_cycle("post_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_param_hex_counter
